ddr_responder: RTL and testbench
================================

DDR_RESPONDER -- requirements
Module: ddr_responder

Interface
REQ-001 SHALL have parameter MEM_DEPTH_LOG2, default 12, meaning log2 of the number of 64-bit memory words.
REQ-002 SHALL have parameter ACCESS_LAT, default 4, meaning WAIT-state cycles per access (legal range 1..15).
REQ-003 SHALL have port clock, input, 1 bit: rising-edge clock.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port ddr_chip_enable, input, 1 bit: command strobe.
REQ-006 SHALL have port ddr_index, input, 19 bits: 64-bit word index.
REQ-007 SHALL have port ddr_write_enable, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port ddr_burst_mode, input, 1 bit: 1 = 8-word burst read.
REQ-009 SHALL have port ddr_opstore_write_mask, input, 64 bits: per-bit write mask.
REQ-010 SHALL have port ddr_opstore_write_data, input, 64 bits: write data.
REQ-011 SHALL have port ddr_opload_read_data, output, 64 bits: single-read data.
REQ-012 SHALL have port ddr_pc_read_inst, output, 512 bits: burst-read data, word i at bits [64i+63:64i].
REQ-013 SHALL have port ddr_operation_done, output, 1 bit: one-cycle completion pulse.
REQ-014 SHALL have port ddr_ready, output, 1 bit: high when a command can be accepted.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, BURST, DONE; ddr_ready=1 only in IDLE and DONE.
REQ-016 SHALL accept a command in any cycle where ddr_chip_enable=1 and ddr_ready=1, capturing index, write_enable, burst_mode, mask and data, then enter WAIT.
REQ-017 SHALL ignore ddr_chip_enable while ddr_ready=0: no capture, no state change.
REQ-018 SHALL form the word address as ddr_index[MEM_DEPTH_LOG2-1:0]; upper bits are ignored, so addresses wrap modulo memory depth.
REQ-019 SHALL hold WAIT for exactly ACCESS_LAT cycles via a down-counter loaded with ACCESS_LAT-1 on accept.
REQ-020 SHALL, at WAIT exit, go to DONE for a single read or any write, and to BURST for a read with burst_mode=1.
REQ-021 SHALL treat a write with burst_mode=1 as a single-word write.
REQ-022 SHALL align the burst base to an 8-word boundary (address[2:0] forced to 0) and read words 0..7 in order, one per cycle, over 8 BURST cycles.
REQ-023 SHALL commit a write to memory on the clock edge entering DONE.
REQ-024 SHALL, for a read, load ddr_opload_read_data (single) or ddr_pc_read_inst (burst) on the edge entering DONE; both hold their value until the next read of the same kind completes.
REQ-025 SHALL assert ddr_operation_done for exactly the one DONE cycle of every operation, including writes.
REQ-026 SHALL, from DONE, go to WAIT if a new command is accepted that cycle, else to IDLE.
REQ-027 SHALL set latency for a single access to done in cycle accept+ACCESS_LAT+1, and for a burst to done in cycle accept+ACCESS_LAT+9.
REQ-028 SHALL give a read accepted in a write's DONE cycle the newly written data.

Reset
REQ-029 SHALL, on reset_n low at any time including mid-operation, immediately force IDLE, ddr_ready=1, ddr_operation_done=0, both read-data outputs 0, and counters 0; any pending write is discarded.
REQ-030 SHALL NOT reset memory contents.

Configuration
REQ-031 SHALL, with macro DDR_RESP_WMASK_EN defined, write memory as (old & ~mask) | (data & mask).
REQ-032 SHALL, with DDR_RESP_WMASK_EN undefined, write the full data word and ignore ddr_opstore_write_mask.

Verification
REQ-033 Bench SHALL check: reset mid-WAIT -> ddr_ready=1 and outputs 0 in the next cycle, with no memory change.
REQ-034 Bench SHALL check: write index 0x10, data 0xDEADBEEF_CAFEF00D, mask all-ones, then single read 0x10 -> done 5 cycles after accept (ACCESS_LAT=4) with read data 0xDEADBEEF_CAFEF00D.
REQ-035 Bench SHALL check: with DDR_RESP_WMASK_EN, write 0xFFFF...FF over 0 with mask 0x00000000_FFFFFFFF -> readback 0x00000000_FFFFFFFF; without the macro -> readback all-ones.
REQ-036 Bench SHALL check: words 0x20..0x27 preloaded with value=index, then burst read at index 0x23 -> done 13 cycles after accept, ddr_pc_read_inst word i = 0x20+i.
REQ-037 Bench SHALL check: command accepted in a DONE cycle -> no IDLE cycle in between, and done pulses separated by exactly ACCESS_LAT+1 cycles.
REQ-038 Bench SHALL check: chip_enable pulsed during BURST -> ignored, a single done pulse, and ddr_opload_read_data unchanged.

Source files
------------

// File: rtl/ddr_responder.sv
// Behavioural DDR memory responder: fixed-latency single reads/writes and 8-word aligned burst reads.
// Optional macro DDR_RESP_WMASK_EN enables per-bit write masking; without it writes replace the whole word.
module ddr_responder #(
    parameter int MEM_DEPTH_LOG2 = 12,
    parameter int ACCESS_LAT     = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         ddr_chip_enable,
    input  logic [18:0]  ddr_index,
    input  logic         ddr_write_enable,
    input  logic         ddr_burst_mode,
    input  logic [63:0]  ddr_opstore_write_mask,
    input  logic [63:0]  ddr_opstore_write_data,
    output logic [63:0]  ddr_opload_read_data,
    output logic [511:0] ddr_pc_read_inst,
    output logic         ddr_operation_done,
    output logic         ddr_ready
);

    localparam int AW = MEM_DEPTH_LOG2;
    localparam int MEM_DEPTH = 1 << MEM_DEPTH_LOG2;
    localparam logic [3:0] LAT_M1 = 4'(ACCESS_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BURST,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [2:0]     beat_q, beat_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           we_q, we_d;
    logic           burst_q, burst_d;
    logic [63:0]    wdata_q, wdata_d;
    logic [63:0]    rdata_q, rdata_d;
    logic [511:0]   inst_q, inst_d;
    logic [511:0]   buf_q, buf_d;
`ifdef DDR_RESP_WMASK_EN
    logic [63:0]    mask_q, mask_d;
`endif

    logic [63:0]    mem [MEM_DEPTH];
    logic           mem_we;
    logic [AW-1:0]  rd_addr;
    logic [63:0]    mem_rd;
    logic [63:0]    mem_wdata;
    logic           accept;
    logic           unused_index;

    assign ddr_ready          = (state_q == S_IDLE) || (state_q == S_DONE);
    assign ddr_operation_done = (state_q == S_DONE);
    assign ddr_opload_read_data = rdata_q;
    assign ddr_pc_read_inst   = inst_q;
    assign accept             = ddr_chip_enable & ddr_ready;
    assign unused_index       = ^ddr_index[18:AW];

    // Bursts walk the aligned 8-word block; otherwise the read port follows the captured address.
    assign rd_addr = (state_q == S_BURST) ? {addr_q[AW-1:3], beat_q} : addr_q;
    assign mem_rd  = mem[rd_addr];

`ifdef DDR_RESP_WMASK_EN
    // In WAIT the read port sits on addr_q, so mem_rd is the old word being merged.
    assign mem_wdata = (mem_rd & ~mask_q) | (wdata_q & mask_q);
`else
    logic unused_mask;
    assign unused_mask = ^ddr_opstore_write_mask;
    assign mem_wdata   = wdata_q;
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        we_d    = we_q;
        burst_d = burst_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        inst_d  = inst_q;
        buf_d   = buf_q;
        mem_we  = 1'b0;
`ifdef DDR_RESP_WMASK_EN
        mask_d  = mask_q;
`endif

        // accept can only be high in IDLE or DONE.
        if (accept) begin
            state_d = S_WAIT;
            cnt_d   = LAT_M1;
            addr_d  = ddr_index[AW-1:0];
            we_d    = ddr_write_enable;
            burst_d = ddr_burst_mode;
            wdata_d = ddr_opstore_write_data;
`ifdef DDR_RESP_WMASK_EN
            mask_d  = ddr_opstore_write_mask;
`endif
        end

        case (state_q)
            S_IDLE: ;
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    if (we_q) begin
                        mem_we  = 1'b1;
                        state_d = S_DONE;
                    end else if (burst_q) begin
                        beat_d  = 3'd0;
                        state_d = S_BURST;
                    end else begin
                        rdata_d = mem_rd;
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_BURST: begin
                buf_d[{beat_q, 6'b0} +: 64] = mem_rd;
                beat_d = beat_q + 3'd1;
                if (beat_q == 3'd7) begin
                    inst_d  = buf_d;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!accept) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            beat_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            burst_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            inst_q  <= '0;
            buf_q   <= '0;
`ifdef DDR_RESP_WMASK_EN
            mask_q  <= '0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            burst_q <= burst_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            inst_q  <= inst_d;
            buf_q   <= buf_d;
`ifdef DDR_RESP_WMASK_EN
            mask_q  <= mask_d;
`endif
        end
    end

    // NOTE: memory contents are deliberately not reset; a reset only aborts the pending write via state_q.
    always_ff @(posedge clock) begin
        if (mem_we) mem[addr_q] <= mem_wdata;
    end

endmodule

// File: tb/tb_ddr_responder.sv
// Directed self-checking bench for ddr_responder (default parameters, ACCESS_LAT = 4).
// Expected values are hand-computed; DDR_RESP_WMASK_EN selects the masked-write expectation.
module tb_ddr_responder;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         ddr_chip_enable;
    logic [18:0]  ddr_index;
    logic         ddr_write_enable;
    logic         ddr_burst_mode;
    logic [63:0]  ddr_opstore_write_mask;
    logic [63:0]  ddr_opstore_write_data;
    logic [63:0]  ddr_opload_read_data;
    logic [511:0] ddr_pc_read_inst;
    logic         ddr_operation_done;
    logic         ddr_ready;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    ddr_responder dut (
        .clock                  (clock),
        .reset_n                (reset_n),
        .ddr_chip_enable        (ddr_chip_enable),
        .ddr_index              (ddr_index),
        .ddr_write_enable       (ddr_write_enable),
        .ddr_burst_mode         (ddr_burst_mode),
        .ddr_opstore_write_mask (ddr_opstore_write_mask),
        .ddr_opstore_write_data (ddr_opstore_write_data),
        .ddr_opload_read_data   (ddr_opload_read_data),
        .ddr_pc_read_inst       (ddr_pc_read_inst),
        .ddr_operation_done     (ddr_operation_done),
        .ddr_ready              (ddr_ready)
    );

    always #5 clock = ~clock;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef DDR_RESP_WMASK_EN
    localparam logic [63:0] EXP_MASKED = 64'h0000_0000_FFFF_FFFF;
`else
    localparam logic [63:0] EXP_MASKED = 64'hFFFF_FFFF_FFFF_FFFF;
`endif

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Presents one command for a single clock edge, then drops chip enable.
    task automatic cmd(input logic [18:0] idx, input logic we, input logic bm,
                       input logic [63:0] mask, input logic [63:0] data);
        ddr_chip_enable        = 1'b1;
        ddr_index              = idx;
        ddr_write_enable       = we;
        ddr_burst_mode         = bm;
        ddr_opstore_write_mask = mask;
        ddr_opstore_write_data = data;
        step();
        ddr_chip_enable        = 1'b0;
    endtask

    // Cycle offset from the accept cycle to the observed done cycle (40 = timed out).
    task automatic wait_done(output int lat);
        lat = 1;
        while (!ddr_operation_done && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic write_word(input string tag, input logic [18:0] idx,
                              input logic [63:0] data, input logic [63:0] mask);
        int lat;
        cmd(idx, 1'b1, 1'b0, mask, data);
        wait_done(lat);
        check({tag, "_lat"}, 512'(lat), 512'd5);
    endtask

    task automatic read_word(input string tag, input logic [18:0] idx, input logic [63:0] exp);
        int lat;
        cmd(idx, 1'b0, 1'b0, ONES, 64'd0);
        wait_done(lat);
        check({tag, "_lat"}, 512'(lat), 512'd5);
        check({tag, "_data"}, 512'(ddr_opload_read_data), 512'(exp));
    endtask

    initial begin
        int lat;
        int first_done;
        int n_done;

        reset_n                = 1'b0;
        ddr_chip_enable        = 1'b0;
        ddr_index              = '0;
        ddr_write_enable       = 1'b0;
        ddr_burst_mode         = 1'b0;
        ddr_opstore_write_mask = '0;
        ddr_opstore_write_data = '0;
        repeat (3) step();
        check("rst_ready", 512'(ddr_ready), 512'd1);
        check("rst_done", 512'(ddr_operation_done), 512'd0);
        check("rst_rdata", 512'(ddr_opload_read_data), 512'd0);
        check("rst_inst", ddr_pc_read_inst, 512'd0);
        reset_n = 1'b1;
        step();

        // Write then single read at 0x10.
        write_word("wr10", 19'h10, 64'hDEADBEEF_CAFEF00D, ONES);
        read_word("rd10", 19'h10, 64'hDEADBEEF_CAFEF00D);

        // Reset during WAIT of a pending write: async effect, write discarded.
        cmd(19'h10, 1'b1, 1'b0, ONES, 64'h1111_1111_1111_1111);
        step();
        check("midwait_busy", 512'(ddr_ready), 512'd0);
        reset_n = 1'b0;
        #1;
        check("midrst_ready", 512'(ddr_ready), 512'd1);
        check("midrst_done", 512'(ddr_operation_done), 512'd0);
        check("midrst_rdata", 512'(ddr_opload_read_data), 512'd0);
        step();
        reset_n = 1'b1;
        step();
        check("postrst_ready", 512'(ddr_ready), 512'd1);
        read_word("rd10_after_rst", 19'h10, 64'hDEADBEEF_CAFEF00D);

        // Masked write of all-ones over zero.
        write_word("wr30_zero", 19'h30, 64'd0, ONES);
        write_word("wr30_mask", 19'h30, ONES, 64'h0000_0000_FFFF_FFFF);
        read_word("rd30", 19'h30, EXP_MASKED);

        // Upper index bits are ignored: 0x41010 aliases word 0x10.
        read_word("rd_wrap", 19'h41010, 64'hDEADBEEF_CAFEF00D);

        // Burst at 0x23 reads aligned block 0x20..0x27; a strobe mid-burst must be ignored.
        for (int i = 0; i < 8; i++) write_word("preload", 19'(32'h20 + i), 64'(32'h20 + i), ONES);
        cmd(19'h23, 1'b0, 1'b1, ONES, 64'd0);
        first_done = 0;
        n_done = 0;
        for (int l = 1; l <= 25; l++) begin
            if (ddr_operation_done) begin
                n_done++;
                if (first_done == 0) first_done = l;
            end
            if (l == 7) begin
                ddr_chip_enable  = 1'b1;
                ddr_index        = 19'h30;
                ddr_write_enable = 1'b0;
                ddr_burst_mode   = 1'b0;
            end else begin
                ddr_chip_enable  = 1'b0;
            end
            step();
        end
        check("burst_lat", 512'(first_done), 512'd13);
        check("burst_ndone", 512'(n_done), 512'd1);
        for (int i = 0; i < 8; i++)
            check($sformatf("burst_w%0d", i), 512'(ddr_pc_read_inst[64*i +: 64]), 512'(32'h20 + i));
        check("burst_rdata_hold", 512'(ddr_opload_read_data), 512'(64'hDEADBEEF_CAFEF00D));

        // Read accepted in a write's DONE cycle: no IDLE gap, fresh data, pulses ACCESS_LAT+1 apart.
        cmd(19'h40, 1'b1, 1'b0, ONES, 64'h01234567_89ABCDEF);
        wait_done(lat);
        check("b2b_wr_lat", 512'(lat), 512'd5);
        check("b2b_ready_done", 512'(ddr_ready), 512'd1);
        cmd(19'h40, 1'b0, 1'b0, ONES, 64'd0);
        check("b2b_no_idle", 512'(ddr_ready), 512'd0);
        wait_done(lat);
        check("b2b_gap", 512'(lat), 512'd5);
        check("b2b_rdata", 512'(ddr_opload_read_data), 512'(64'h01234567_89ABCDEF));

        // Write with burst_mode set behaves as a single-word write.
        cmd(19'h50, 1'b1, 1'b1, ONES, 64'h55);
        wait_done(lat);
        check("wrburst_lat", 512'(lat), 512'd5);
        step();
        check("idle_after_done", 512'(ddr_ready & ~ddr_operation_done), 512'd1);
        read_word("rd50", 19'h50, 64'h55);
        read_word("rd51_untouched", 19'h51, 64'h0 | 64'(dut.mem[81]));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
